// File: rtl/intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intr_ctrl_pkg
// Shared definitions for the interrupt controller: FSM state encodings and
// config-bus register addresses. Imported by intr_ctrl.
// -----------------------------------------------------------------------------
package intr_ctrl_pkg;

  // Encodings are visible to software through STATUS[9:8], so they are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_e;

  localparam logic [1:0] REG_PENDING = 2'd0;  // R/W1C
  localparam logic [1:0] REG_MASK    = 2'd1;  // RW
  localparam logic [1:0] REG_STATUS  = 2'd2;  // RO

  localparam int STATUS_STATE_LSB = 8;

endpackage

// File: rtl/intr_edge_detect.sv
// -----------------------------------------------------------------------------
// intr_edge_detect
// One interrupt line: optional two-flop synchroniser, then a previous-value
// flop; rise pulses for one cycle on each 0->1 transition of the line.
//
// Macro INTR_SYNC_EN: when defined, src is treated as asynchronous and passes
// through two flops first (two extra cycles of latency). When undefined, src
// must already be synchronous to clk and rise is combinational from it.
//
// Ports:
//   clk   in  main clock
//   rst   in  asynchronous active-high reset
//   src   in  raw interrupt line (level)
//   rise  out one-cycle pulse on a rising edge of the (synchronised) line
// -----------------------------------------------------------------------------
module intr_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  logic sync_out;
  logic prev;

`ifdef INTR_SYNC_EN
  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // two-flop chain into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= src;
      sync_out <= meta;
    end
  end
`else
  assign sync_out = src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sync_out;
  end

  assign rise = sync_out & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Multi-source interrupt controller in front of mips_core. Edge-detects N_SRC
// lines into pending bits, masks them, and offers the lowest-index eligible
// source to the core via an irq / irq_ack / eret handshake.
//
// Macro INTR_SYNC_EN: adds a two-flop synchroniser per source (see
// intr_edge_detect). Default build has it off.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   src        raw interrupt lines
//   cfg_wen    config write strobe
//   cfg_addr   0=PENDING (W1C) 1=MASK 2=STATUS (RO) 3=reserved (reads 0)
//   cfg_din    config write data, bits [N_SRC-1:0] used
//   cfg_dout   config read data, combinational from cfg_addr
//   irq        registered interrupt request
//   irq_id     registered index of requested source, valid while irq=1
//   irq_ack    core accepts the request (pulse)
//   eret       core leaves the handler (pulse)
// -----------------------------------------------------------------------------
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             cfg_wen,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_din,
  output logic [31:0]      cfg_dout,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             eret
);

  intr_state_e      state;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  isr_id;
  logic             unused_cfg_bits;

  for (genvar i = 0; i < N_SRC; i++) begin : g_edge
    intr_edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .src  (src[i]),
      .rise (rise[i])
    );
  end

  // Fixed priority: scanning downward leaves the lowest set index.
  function automatic logic [ID_W-1:0] pick_winner(input logic [N_SRC-1:0] v);
    pick_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) pick_winner = ID_W'(i);
    end
  endfunction

  // Uses the registered mask, so a MASK write affects eligibility next cycle.
  assign eligible = pending & mask;
  assign winner   = pick_winner(eligible);

  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    clr = '0;
    if (cfg_wen && cfg_addr == REG_PENDING) clr = cfg_din[N_SRC-1:0];
    if (state == ST_REQ && irq_ack)         clr = clr | (N_SRC'(1) << irq_id);
  end

  // OR-ing rise after clearing makes a coincident new edge win over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      mask    <= '1;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (cfg_wen && cfg_addr == REG_MASK) mask <= cfg_din[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      irq    <= 1'b0;
      irq_id <= '0;
      isr_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state  <= ST_REQ;
            irq    <= 1'b1;
            irq_id <= winner;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state  <= ST_SERVICE;
            isr_id <= irq_id;
            irq    <= 1'b0;
          end else if (!(|eligible)) begin
            // Request withdrawn by W1C or mask before the core took it.
            state <= ST_IDLE;
            irq   <= 1'b0;
          end else begin
            irq_id <= winner;
          end
        end
        ST_SERVICE: begin
          // No nesting: new edges only accumulate in pending.
          if (eret) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_dout = '0;
    case (cfg_addr)
      REG_PENDING: cfg_dout[N_SRC-1:0] = pending;
      REG_MASK:    cfg_dout[N_SRC-1:0] = mask;
      REG_STATUS: begin
        cfg_dout[STATUS_STATE_LSB +: 2] = state;
        cfg_dout[ID_W-1:0]              = isr_id;
      end
      default:     cfg_dout = '0;
    endcase
  end

  assign unused_cfg_bits = ^cfg_din[31:N_SRC];

endmodule
